// File: rtl/fetch_queue_pkg.sv
// Shared constants, the buffered-instruction record and the PC alignment helper for fetch_queue.
// Optional build macro used by the top: FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned PC_W   = 32;

   localparam logic [PC_W-1:0] PC_STEP   = 32'd4;
   localparam logic [PC_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] data;
   } fq_entry_t;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return addr & WORD_MASK;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode handshakes of fetch_queue.
// master = the fetch queue itself, slave = memory/decode/branch environment.
interface fetch_queue_if;
   import fetch_queue_pkg::*;

   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              mem_req_valid;
   logic [PC_W-1:0]   mem_req_addr;
   logic              mem_req_ready;
   logic              mem_rsp_valid;
   logic [INST_W-1:0] mem_rsp_data;
   logic              inst_valid;
   logic [INST_W-1:0] inst_data;
   logic [PC_W-1:0]   inst_pc;
   logic              inst_ready;

   modport master (
      input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
      input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush, occupancy count and a combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty     = (count_q == {CW{1'b0}});
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Pointer, occupancy and storage update; flush empties the queue but leaves storage contents.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // State registers; storage clears on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with credit-limited requests, in-order responses, redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when nothing is buffered.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master bus
);

   localparam int unsigned CW         = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            run_q;

   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   in_flight;
   logic            fifo_empty, fifo_full;
   logic            tag_empty, tag_full;
   fq_entry_t       fifo_head;
   fq_entry_t       fifo_wdata;
   logic [PC_W-1:0] tag_head;
   logic [CW:0]     credit_used;
   logic            inst_valid;
   logic            req_fire, rsp_take, rsp_keep, byp;
   logic            fifo_push, fifo_pop, tag_push;

   // Every buffered or outstanding instruction holds one credit; run_q masks the reset cycle.
   assign credit_used       = {1'b0, fifo_count} + {1'b0, in_flight};
   assign bus.mem_req_valid = run_q && (credit_used < CREDIT_MAX) && !bus.redirect_valid;
   assign bus.mem_req_addr  = fetch_pc_q;
   assign inst_valid        = !bus.redirect_valid && (!fifo_empty || byp);
   assign bus.inst_valid    = inst_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bus.inst_data = fifo_empty ? bus.mem_rsp_data : fifo_head.data;
   assign bus.inst_pc   = fifo_empty ? tag_head : fifo_head.pc;
`else
   assign bus.inst_data = fifo_head.data;
   assign bus.inst_pc   = fifo_head.pc;
`endif

   // Handshake decode: which response is kept, forwarded, buffered, and which entry leaves.
   always_comb begin
      req_fire   = bus.mem_req_valid && bus.mem_req_ready;
      rsp_take   = bus.mem_rsp_valid && !tag_empty;
      rsp_keep   = rsp_take && !bus.redirect_valid && (drop_q == {CW{1'b0}});
`ifdef FETCH_QUEUE_BYPASS_EN
      byp        = rsp_keep && fifo_empty;
`else
      byp        = 1'b0;
`endif
      fifo_pop   = inst_valid && bus.inst_ready && !fifo_empty;
      fifo_push  = rsp_keep && !(byp && bus.inst_ready) && !fifo_full;
      tag_push   = req_fire && !tag_full;
      fifo_wdata = '{pc: tag_head, data: bus.mem_rsp_data};
   end

   // Fetch PC and stale-response counter; a redirect discards everything still outstanding.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = word_align(bus.redirect_pc);
         drop_d     = in_flight - CW'(rsp_take);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (rsp_take && (drop_q != {CW{1'b0}})) begin
            drop_d = drop_q - CW'(1'b1);
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= {CW{1'b0}};
         run_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
         run_q      <= 1'b1;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fq_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.redirect_valid),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Tags are never flushed: dropped responses still arrive and must retire their tag.
   fetch_fifo #(
      .WIDTH (PC_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (tag_push),
      .push_data (fetch_pc_q),
      .pop       (rsp_take),
      .head_data (tag_head),
      .count     (in_flight),
      .empty     (tag_empty),
      .full      (tag_full)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based model of the fetch contract.
// Honours FETCH_QUEUE_BYPASS_EN for the expected response-to-decode latency.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int LAT = 0;
   localparam bit BYP = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit BYP = 1'b0;
`endif

   typedef struct { logic [31:0] pc; bit stale; } os_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   os_t  os_q[$];
   ent_t bq[$];
   mp_t  pipe[$];
   logic [31:0] m_pc;
   bit   started;
   int   cyc, last_due;
   int   n_checks, n_fail;
   int   p_ready, p_iready, p_redir, dmin, dmax;
   bit   redir_force;
   logic [31:0] redir_force_pc;
   bit   cap_fire, cap_inst, cap_lat;
   logic [31:0] first_fire_addr, first_inst_pc;
   int   fires, lat_rsp_cyc, lat_inst_cyc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = 32'h0;
      bus.inst_ready     = 1'b0;
      pipe.delete();
      os_q.delete();
      bq.delete();
      started  = 1'b0;
      m_pc     = RPC;
      last_due = cyc;
      #1;
      check_eq("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
      check_eq("rst_req_addr", bus.mem_req_addr, RPC);
      check_eq("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
      check_eq("rst_inst_data", bus.inst_data, 32'h0);
      check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
      @(posedge clk);
      started = 1'b1;
   endtask

   task automatic cycle();
      bit rsp_v, redir, exp_rv, exp_iv, byp, fire, dut_fire, iready;
      logic [31:0] rpc, dut_addr;
      ent_t e;
      os_t  o;
      mp_t  m;
      int   d;
      @(negedge clk);
      if (redir_force) begin
         redir = 1'b1;
         rpc   = redir_force_pc;
      end else begin
         redir = ($urandom_range(999) < p_redir);
         rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'h3)) : $urandom();
      end
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.mem_req_ready  = ($urandom_range(99) < p_ready);
      iready             = ($urandom_range(99) < p_iready);
      bus.inst_ready     = iready;
      rsp_v              = (pipe.size() > 0) && (pipe[0].due <= cyc);
      bus.mem_rsp_valid  = rsp_v;
      bus.mem_rsp_data   = rsp_v ? memfn(pipe[0].addr) : $urandom();
      #1;
      exp_rv = started && ((bq.size() + os_q.size()) < DEPTH) && !redir;
      byp    = BYP && rsp_v && !redir && (bq.size() == 0) && (os_q.size() > 0) && !os_q[0].stale;
      exp_iv = !redir && ((bq.size() > 0) || byp);
      check_eq("req_valid", {31'h0, bus.mem_req_valid}, {31'h0, exp_rv});
      check_eq("req_addr", bus.mem_req_addr, m_pc);
      check_eq("inst_valid", {31'h0, bus.inst_valid}, {31'h0, exp_iv});
      if (exp_iv) begin
         if (bq.size() > 0) begin
            e = bq[0];
         end else begin
            e.pc   = os_q[0].pc;
            e.data = memfn(os_q[0].pc);
         end
         check_eq("inst_pc", bus.inst_pc, e.pc);
         check_eq("inst_data", bus.inst_data, e.data);
      end
      if (cap_inst && bus.inst_valid && iready) begin
         first_inst_pc = bus.inst_pc;
         cap_inst      = 1'b0;
      end
      if (cap_lat && rsp_v && (lat_rsp_cyc < 0)) lat_rsp_cyc = cyc;
      if (cap_lat && bus.inst_valid && (lat_inst_cyc < 0)) lat_inst_cyc = cyc;
      dut_fire = bus.mem_req_valid && bus.mem_req_ready;
      dut_addr = bus.mem_req_addr;
      fire     = exp_rv && bus.mem_req_ready;
      if (cap_fire && dut_fire) begin
         first_fire_addr = dut_addr;
         cap_fire        = 1'b0;
      end
      @(posedge clk);
      cyc++;
      if (redir) begin
         bq.delete();
         foreach (os_q[i]) os_q[i].stale = 1'b1;
      end else if (exp_iv && iready && !byp) begin
         void'(bq.pop_front());
      end
      if (rsp_v && (os_q.size() > 0)) begin
         o = os_q.pop_front();
         if (!o.stale && !(byp && iready)) begin
            e.pc   = o.pc;
            e.data = memfn(o.pc);
            bq.push_back(e);
         end
      end
      if (fire) begin
         o.pc    = m_pc;
         o.stale = 1'b0;
         os_q.push_back(o);
         m_pc = m_pc + 32'd4;
      end
      if (redir) m_pc = rpc & 32'hFFFF_FFFC;
      if (rsp_v) void'(pipe.pop_front());
      if (dut_fire) begin
         fires++;
         d = $urandom_range(dmax, dmin);
         m.addr = dut_addr;
         m.due  = cyc + d - 1;
         if (m.due <= last_due) m.due = last_due + 1;
         last_due = m.due;
         pipe.push_back(m);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; fires = 0;
      redir_force = 1'b0; redir_force_pc = 32'h0;
      cap_fire = 1'b0; cap_inst = 1'b0; cap_lat = 1'b0;
      p_ready = 100; p_iready = 100; p_redir = 0; dmin = 1; dmax = 1;

      // Streaming from reset with a single-cycle memory.
      do_reset();
      cap_inst = 1'b1; cap_lat = 1'b1; lat_rsp_cyc = -1; lat_inst_cyc = -1;
      first_inst_pc = 32'hDEAD_BEEF;
      repeat (20) cycle();
      cap_lat = 1'b0;
      check_eq("first_inst_pc", first_inst_pc, RPC);
      check_eq("rsp_to_inst_lat", lat_inst_cyc - lat_rsp_cyc, LAT);

      // Decode stalled: credits stop fetch at DEPTH, then resume in order.
      do_reset();
      p_iready = 0; fires = 0;
      repeat (10) cycle();
      check_eq("stall_req_count", fires, DEPTH);
      p_iready = 100; cap_fire = 1'b1; first_fire_addr = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && cap_fire; i++) cycle();
      check_eq("resume_addr", first_fire_addr, RPC + 32'h10);

      // Redirect with three requests outstanding and a response landing that cycle.
      do_reset();
      dmin = 3; dmax = 3;
      for (int i = 0; i < 10 && os_q.size() < 3; i++) cycle();
      check_eq("inflight_before_redir", os_q.size(), 3);
      redir_force = 1'b1; redir_force_pc = 32'h0000_0203;
      cap_fire = 1'b1; cap_inst = 1'b1;
      first_fire_addr = 32'hDEAD_BEEF; first_inst_pc = 32'hDEAD_BEEF;
      cycle();
      redir_force = 1'b0;
      for (int i = 0; i < 30 && (cap_fire || cap_inst); i++) cycle();
      check_eq("redir_first_req", first_fire_addr, 32'h0000_0200);
      check_eq("redir_first_inst", first_inst_pc, 32'h0000_0200);

      // Random backpressure, variable latency, redirects including near the address wrap.
      p_ready = 70; p_iready = 70; p_redir = 30; dmin = 1; dmax = 3;
      repeat (4000) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
